if_fetch_queue: RTL

Parametrised instruction-fetch front end with a prefetch queue: holds the fetch PC, runs a one-outstanding-request read handshake to the instruction memory system, and buffers returned instructions in a DEPTH-entry FIFO. Decode pops from the head, and a redirect from ID, EX or MEM flushes the queue and restarts fetch. Memory latency is decoupled from decode stalls, and a NOP is presented whenever the queue is empty. It replaces the single-slot fetch stage in the pipeline.

---
 rtl/if_fetch_queue.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: fetch PC, one-outstanding-request memory
// handshake, and a DEPTH-entry prefetch queue feeding decode.
module if_fetch_queue #(
    parameter int unsigned      WIDTH    = 16,
    parameter int unsigned      DEPTH    = 4,
    parameter int unsigned      PC_STEP  = 2,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter logic [WIDTH-1:0] NOP      = WIDTH'(16'h0800)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             halt_n,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    input  logic             stall,
    output logic             mem_rd,
    output logic [WIDTH-1:0] mem_addr,
    input  logic             mem_done,
    input  logic [WIDTH-1:0] mem_data,
    input  logic             mem_err,
    output logic [WIDTH-1:0] inst,
    output logic [WIDTH-1:0] inst_pc2,
    output logic             inst_valid,
    output logic             inst_err
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DROP = 2'd2
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] inst;
        logic [WIDTH-1:0] pc2;
        logic             err;
    } entry_t;

    state_t           state;
    logic [WIDTH-1:0] pc;
    entry_t           fifo [DEPTH];
    entry_t           head;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;

    logic             pop;
    logic             push;
    logic             flush;
    logic [CW-1:0]    count_next;
    logic             room;
    logic             issue_ok;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] addr_inc;

    // Queue head presentation; empty queue shows NOP with cleared side fields.
    assign head       = fifo[rd_ptr];
    assign inst_valid = (count != '0);
    assign inst       = inst_valid ? head.inst : NOP;
    assign inst_pc2   = inst_valid ? head.pc2  : '0;
    assign inst_err   = inst_valid ? head.err  : 1'b0;

    // Per-cycle queue control and issue permission.
    always_comb begin
        pop        = inst_valid & ~stall;
        push       = (state == BUSY) & mem_done & ~redirect;
        flush      = redirect;
        pc_inc     = pc + WIDTH'(PC_STEP);
        addr_inc   = mem_addr + WIDTH'(PC_STEP);
        count_next = count + CW'(push) - CW'(pop);
        if (flush) begin
            count_next = '0;
        end
        room     = (count_next < CW'(DEPTH));
        issue_ok = halt_n & room;
    end

    // Queue storage; contents are don't-care while the entry is not counted.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo[wr_ptr] <= '{inst: mem_data, pc2: addr_inc, err: mem_err};
        end
    end

    // Queue pointers and occupancy; a flush overrides any push or pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count_next;
        end
    end

    // Fetch FSM: PC, request address and the registered read strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            mem_rd   <= 1'b0;
            pc       <= RESET_PC;
            mem_addr <= RESET_PC;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect) begin
                        pc <= redirect_pc;
                    end else if (issue_ok) begin
                        mem_addr <= pc;
                        state    <= BUSY;
                        mem_rd   <= 1'b1;
                    end
                end
                BUSY: begin
                    if (redirect) begin
                        // Completing request is discarded; otherwise wait it out.
                        pc <= redirect_pc;
                        if (mem_done) begin
                            state  <= IDLE;
                            mem_rd <= 1'b0;
                        end else begin
                            state <= DROP;
                        end
                    end else if (mem_done) begin
                        pc <= pc_inc;
                        if (issue_ok) begin
                            mem_addr <= pc_inc;
                        end else begin
                            state  <= IDLE;
                            mem_rd <= 1'b0;
                        end
                    end
                end
                DROP: begin
                    if (redirect) begin
                        pc <= redirect_pc;
                    end
                    if (mem_done) begin
                        state  <= IDLE;
                        mem_rd <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    mem_rd <= 1'b0;
                end
            endcase
        end
    end

endmodule
